// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fifo_pkg
// Desc   : Shared FIFO state encoding and pointer-wrap helper.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_t;

    // Wraps at depth-1 so non-power-of-two depths use every slot exactly once.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_flags_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fifo_sync_flags_if
// Desc   : Producer/consumer handshake and status bundle for fifo_sync_flags.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface fifo_sync_flags_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          clear;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output clear, wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fifo_mem
// Desc   : DEPTH x DW register array, synchronous write, registered read.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module fifo_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic          re,
    input  wire logic [AW-1:0] raddr,
    output      logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Storage carries no reset so it maps onto plain flops or RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : fifo_sync_flags
// Desc   : Single-clock FIFO with EMPTY/PARTIAL/FULL FSM, count, threshold
//          flags, synchronous flush and overflow/underflow pulses.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input wire logic          clk,
    input wire logic          rst,
    fifo_sync_flags_if.slave  bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] c_depth  = CW'(DEPTH);
    localparam logic [CW-1:0] c_afull  = CW'(AFULL_TH);
    localparam logic [CW-1:0] c_aempty = CW'(AEMPTY_TH);

    fifo_state_t   r_state;
    fifo_state_t   w_state_next;
    logic [AW-1:0] r_wrp;
    logic [AW-1:0] r_rdp;
    logic [AW-1:0] w_wrp_inc;
    logic [AW-1:0] w_rdp_inc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_full;
    logic          w_empty;
    logic          r_dout_valid;
    logic          r_overflow;
    logic          r_underflow;
    logic [DW-1:0] w_rdata;

    // Acceptance looks only at registered state; clear masks both requests.
    assign w_wr_acc = bus.wr_en && !w_full  && !bus.clear;
    assign w_rd_acc = bus.rd_en && !w_empty && !bus.clear;

    assign w_wrp_inc = AW'(ptr_inc(32'(r_wrp), DEPTH));
    assign w_rdp_inc = AW'(ptr_inc(32'(r_rdp), DEPTH));

    always_comb begin
        w_count_next = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrp        <= '0;
            r_rdp        <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (bus.clear) begin
            r_wrp        <= '0;
            r_rdp        <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_wr_acc) r_wrp <= w_wrp_inc;
            if (w_rd_acc) r_rdp <= w_rdp_inc;
            r_count      <= w_count_next;
            r_dout_valid <= w_rd_acc;
            r_overflow   <= bus.wr_en && w_full;
            r_underflow  <= bus.rd_en && w_empty;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FIFO_EMPTY;
        end else if (bus.clear) begin
            r_state <= FIFO_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FIFO_EMPTY: begin
                if (w_wr_acc) w_state_next = FIFO_PARTIAL;
            end
            FIFO_PARTIAL: begin
                if (w_count_next == c_depth) begin
                    w_state_next = FIFO_FULL;
                end else if (w_count_next == '0) begin
                    w_state_next = FIFO_EMPTY;
                end
            end
            FIFO_FULL: begin
                if (w_rd_acc) w_state_next = FIFO_PARTIAL;
            end
            default: w_state_next = FIFO_EMPTY;
        endcase
    end

    // FSM: output decode
    always_comb begin
        w_full  = 1'b0;
        w_empty = 1'b0;
        case (r_state)
            FIFO_EMPTY: w_empty = 1'b1;
            FIFO_FULL:  w_full  = 1'b1;
            default: begin
                w_full  = 1'b0;
                w_empty = 1'b0;
            end
        endcase
    end

    fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_acc),
        .waddr (r_wrp),
        .wdata (bus.din),
        .re    (w_rd_acc),
        .raddr (r_rdp),
        .rdata (w_rdata)
    );

    assign bus.dout         = w_rdata;
    assign bus.dout_valid   = r_dout_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= c_afull);
    assign bus.almost_empty = (r_count <= c_aempty);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_fifo_sync_flags
// Desc   : Directed self-checking bench for fifo_sync_flags (DEPTH 16 and 10).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_fifo_sync_flags;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fifo_sync_flags_if #(.DW(8), .DEPTH(16)) b16 ();
    fifo_sync_flags_if #(.DW(8), .DEPTH(10)) b10 ();

    fifo_sync_flags #(.DW(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    fifo_sync_flags #(.DW(8), .DEPTH(10), .AFULL_TH(8), .AEMPTY_TH(2)) u_dut10 (
        .clk (clk),
        .rst (rst),
        .bus (b10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs at a falling edge, let one rising edge act, return at the next falling edge.
    task automatic cyc16(input logic w, input logic r, input logic [7:0] d, input logic c);
        b16.wr_en = w; b16.rd_en = r; b16.din = d; b16.clear = c;
        @(negedge clk);
        b16.wr_en = 1'b0; b16.rd_en = 1'b0; b16.clear = 1'b0;
    endtask

    task automatic cyc10(input logic w, input logic r, input logic [7:0] d);
        b10.wr_en = w; b10.rd_en = r; b10.din = d;
        @(negedge clk);
        b10.wr_en = 1'b0; b10.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (b16.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", b16.empty); end
        checks++; if (b16.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", b16.full); end
        checks++; if (b16.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", b16.count); end
        checks++; if (b16.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b want 1", b16.almost_empty); end
        checks++; if (b16.almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", b16.almost_full); end
        checks++; if (b16.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", b16.dout); end
        checks++; if ({b16.dout_valid, b16.overflow, b16.underflow} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {b16.dout_valid, b16.overflow, b16.underflow}); end
        checks++; if (b10.empty !== 1'b1 || b10.count !== 4'd0) begin errors++; $display("FAIL reset_d10: got empty=%b count=%0d want 1/0", b10.empty, b10.count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            cyc16(1'b1, 1'b0, 8'(i), 1'b0);
            checks++; if (b16.count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, b16.count, i); end
            checks++; if (b16.full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, b16.full, (i == 16)); end
            checks++; if (b16.almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_afull[%0d]: got %b want %b", i, b16.almost_full, (i >= 14)); end
            checks++; if (b16.almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, b16.almost_empty, (i <= 2)); end
        end
        cyc16(1'b1, 1'b0, 8'hEE, 1'b0);
        checks++; if (b16.overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse: got %b want 1", b16.overflow); end
        checks++; if (b16.count !== 5'd16) begin errors++; $display("FAIL overflow_count: got %0d want 16", b16.count); end
        cyc16(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (b16.overflow !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle: got %b want 0", b16.overflow); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            cyc16(1'b0, 1'b1, 8'h00, 1'b0);
            checks++; if (b16.dout !== 8'(i) || b16.dout_valid !== 1'b1) begin errors++; $display("FAIL drain_data[%0d]: got %h/%b want %h/1", i, b16.dout, b16.dout_valid, 8'(i)); end
            checks++; if (b16.count !== 5'(16 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, b16.count, 16 - i); end
        end
        checks++; if (b16.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", b16.empty); end
        cyc16(1'b0, 1'b1, 8'h00, 1'b0);
        checks++; if (b16.underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse: got %b want 1", b16.underflow); end
        checks++; if (b16.dout_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid: got %b want 0", b16.dout_valid); end
        checks++; if (b16.dout !== 8'h10) begin errors++; $display("FAIL underflow_dout_hold: got %h want 10", b16.dout); end
        cyc16(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if (b16.underflow !== 1'b0) begin errors++; $display("FAIL underflow_one_cycle: got %b want 0", b16.underflow); end
    endtask

    task automatic test_wrap();
        cyc10(1'b1, 1'b0, 8'h40);
        for (int k = 1; k <= 25; k++) begin
            cyc10(1'b1, 1'b1, 8'(8'h40 + k));
            checks++; if (b10.dout !== 8'(8'h40 + k - 1) || b10.dout_valid !== 1'b1) begin errors++; $display("FAIL wrap_data[%0d]: got %h/%b want %h/1", k, b10.dout, b10.dout_valid, 8'(8'h40 + k - 1)); end
            checks++; if (b10.count !== 4'd1) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 1", k, b10.count); end
        end
        cyc10(1'b0, 1'b1, 8'h00);
        checks++; if (b10.dout !== 8'h59 || b10.empty !== 1'b1) begin errors++; $display("FAIL wrap_last: got %h empty=%b want 59 empty=1", b10.dout, b10.empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) cyc16(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        checks++; if (b16.full !== 1'b1) begin errors++; $display("FAIL simul_prefull: got %b want 1", b16.full); end
        cyc16(1'b1, 1'b1, 8'hEE, 1'b0);
        checks++; if (b16.count !== 5'd15 || b16.full !== 1'b0) begin errors++; $display("FAIL simul_full_count: got %0d full=%b want 15 full=0", b16.count, b16.full); end
        checks++; if (b16.overflow !== 1'b1) begin errors++; $display("FAIL simul_full_ovf: got %b want 1", b16.overflow); end
        checks++; if (b16.dout !== 8'h80 || b16.dout_valid !== 1'b1) begin errors++; $display("FAIL simul_full_data: got %h/%b want 80/1", b16.dout, b16.dout_valid); end
        for (int i = 1; i < 16; i++) cyc16(1'b0, 1'b1, 8'h00, 1'b0);
        checks++; if (b16.dout !== 8'h8F || b16.empty !== 1'b1) begin errors++; $display("FAIL simul_dropped_write: got %h empty=%b want 8f empty=1", b16.dout, b16.empty); end
        cyc16(1'b1, 1'b1, 8'h55, 1'b0);
        checks++; if (b16.count !== 5'd1 || b16.underflow !== 1'b1) begin errors++; $display("FAIL simul_empty: got count=%0d unf=%b want 1/1", b16.count, b16.underflow); end
        checks++; if (b16.dout_valid !== 1'b0 || b16.dout !== 8'h8F) begin errors++; $display("FAIL simul_no_bypass: got %h/%b want 8f/0", b16.dout, b16.dout_valid); end
        cyc16(1'b0, 1'b1, 8'h00, 1'b0);
        checks++; if (b16.dout !== 8'h55 || b16.empty !== 1'b1) begin errors++; $display("FAIL simul_empty_data: got %h empty=%b want 55 empty=1", b16.dout, b16.empty); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) cyc16(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        checks++; if (b16.count !== 5'd7) begin errors++; $display("FAIL clear_prefill: got %0d want 7", b16.count); end
        cyc16(1'b1, 1'b1, 8'hFF, 1'b1);
        checks++; if (b16.count !== 5'd0 || b16.empty !== 1'b1) begin errors++; $display("FAIL clear_state: got count=%0d empty=%b want 0/1", b16.count, b16.empty); end
        checks++; if ({b16.overflow, b16.underflow, b16.dout_valid} !== 3'b000) begin errors++; $display("FAIL clear_pulses: got %b want 000", {b16.overflow, b16.underflow, b16.dout_valid}); end
        checks++; if (b16.dout !== 8'h55) begin errors++; $display("FAIL clear_dout_hold: got %h want 55", b16.dout); end
        cyc16(1'b1, 1'b0, 8'h33, 1'b0);
        cyc16(1'b0, 1'b1, 8'h00, 1'b0);
        checks++; if (b16.dout !== 8'h33 || b16.empty !== 1'b1) begin errors++; $display("FAIL clear_new_data: got %h empty=%b want 33 empty=1", b16.dout, b16.empty); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cyc16(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        cyc16(1'b0, 1'b1, 8'h00, 1'b0);
        cyc16(1'b1, 1'b0, 8'hC5, 1'b0);
        checks++; if (b16.count !== 5'd5 || b16.dout_valid !== 1'b0) begin errors++; $display("FAIL arst_precount: got %0d want 5", b16.count); end
        b16.wr_en = 1'b1; b16.din = 8'hC6;
        #2 rst = 1'b1;
        #1;
        checks++; if (b16.count !== 5'd0 || b16.empty !== 1'b1 || b16.full !== 1'b0) begin errors++; $display("FAIL arst_state: got count=%0d empty=%b full=%b want 0/1/0", b16.count, b16.empty, b16.full); end
        checks++; if (b16.almost_empty !== 1'b1 || b16.almost_full !== 1'b0) begin errors++; $display("FAIL arst_almost: got ae=%b af=%b want 1/0", b16.almost_empty, b16.almost_full); end
        checks++; if (b16.dout !== 8'h00 || {b16.dout_valid, b16.overflow, b16.underflow} !== 3'b000) begin errors++; $display("FAIL arst_outputs: got dout=%h pulses=%b want 00/000", b16.dout, {b16.dout_valid, b16.overflow, b16.underflow}); end
        @(negedge clk);
        b16.wr_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (b16.empty !== 1'b1 || b16.count !== 5'd0) begin errors++; $display("FAIL arst_held: got empty=%b count=%0d want 1/0", b16.empty, b16.count); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        b16.clear = 1'b0; b16.wr_en = 1'b0; b16.rd_en = 1'b0; b16.din = 8'h00;
        b10.clear = 1'b0; b10.wr_en = 1'b0; b10.rd_en = 1'b0; b10.din = 8'h00;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
